// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares one async-read flash port between CPU fetch and bulk loader
module flash_port_arbiter #(
  parameter int P_WAIT_CYCLES  = 4,
  parameter int P_CPU_PRIORITY = 1
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic        I_CPU_REQ,
  input  logic [23:0] I_CPU_ADDR,
  output logic        O_CPU_ACK,
  output logic [15:0] O_CPU_DATA,
  input  logic        I_LDR_REQ,
  input  logic [23:0] I_LDR_ADDR,
  output logic        O_LDR_ACK,
  output logic [15:0] O_LDR_DATA,
  output logic        O_BUSY,
  output logic [23:0] O_FLASH_ADDR,
  input  logic [15:0] I_FLASH_DATA,
  output logic        O_FLASH_CE_L,
  output logic        O_FLASH_OE_L,
  output logic        O_ADDR_VALID_L,
  output logic        O_FLASH_WE_L,
  output logic        O_FLASH_CLK
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  state_t state, state_d;
  logic [3:0] cnt;
  logic owner_ldr;
  logic strobe_l;
  logic any_req, grant_cpu, done;
  assign O_FLASH_CE_L   = strobe_l;
  assign O_FLASH_OE_L   = strobe_l;
  assign O_ADDR_VALID_L = strobe_l;
  assign O_FLASH_WE_L   = 1'b1;
  assign O_FLASH_CLK    = 1'b1;
  // owner_ldr doubles as the last-grant record, so the round-robin tie goes to whoever was not served last
  always_comb begin
    any_req   = I_CPU_REQ | I_LDR_REQ;
    grant_cpu = (P_CPU_PRIORITY != 0) ? I_CPU_REQ : I_CPU_REQ & (~I_LDR_REQ | owner_ldr);
    done      = (state == ACCESS) && (cnt == '0);
    state_d   = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
                (state == ACCESS) ? (done ? RECOVER : ACCESS) : IDLE;
  end
  // state register
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) state <= IDLE;
    else state <= state_d;
  end
  // registered strobes, grant latch, wait counter, data capture and ack pulses
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      cnt          <= '0;
      owner_ldr    <= 1'b1;
      strobe_l     <= 1'b1;
      O_BUSY       <= 1'b0;
      O_FLASH_ADDR <= '0;
      O_CPU_ACK    <= 1'b0;
      O_LDR_ACK    <= 1'b0;
      O_CPU_DATA   <= '0;
      O_LDR_DATA   <= '0;
    end else begin
      O_BUSY    <= state_d != IDLE;
      strobe_l  <= state_d != ACCESS;
      O_CPU_ACK <= done & ~owner_ldr;
      O_LDR_ACK <= done & owner_ldr;
      if (state == IDLE && any_req) begin
        O_FLASH_ADDR <= grant_cpu ? I_CPU_ADDR : I_LDR_ADDR;
        owner_ldr    <= ~grant_cpu;
        cnt          <= 4'(P_WAIT_CYCLES - 1);
      end else if (state == ACCESS && !done) begin
        cnt <= cnt - 4'd1;
      end
      if (done && !owner_ldr) O_CPU_DATA <= I_FLASH_DATA;
      if (done && owner_ldr) O_LDR_DATA <= I_FLASH_DATA;
    end
  end
endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb_flash_port_arbiter: directed and randomized checks of the flash port arbiter
module tb_flash_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2], creq[2], lreq[2], beef[2];
  logic [23:0] caddr[2], laddr[2], faddr[2];
  logic cack[2], lack[2], busy[2], ce[2], oe[2], av[2], we[2], fclk[2];
  logic [15:0] cdata[2], ldata[2], fdata[2];
  int checks = 0;
  int failures = 0;
  bit last_c[2];
  logic [15:0] exp_cd[2], exp_ld[2];
  logic [23:0] exp_fa[2];
  function automatic logic [15:0] fmem(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction
  function automatic int wv(input int d);
    return d == 0 ? 4 : 1;
  endfunction
  // instance 0: W=4, CPU priority; instance 1: W=1, round-robin
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign fdata[g] = beef[g] ? 16'hBEEF : fmem(faddr[g]);
    flash_port_arbiter #(.P_WAIT_CYCLES(g == 0 ? 4 : 1), .P_CPU_PRIORITY(g == 0 ? 1 : 0)) u_dut (
      .I_CLK(clk), .I_RESET_L(rst_n[g]),
      .I_CPU_REQ(creq[g]), .I_CPU_ADDR(caddr[g]), .O_CPU_ACK(cack[g]), .O_CPU_DATA(cdata[g]),
      .I_LDR_REQ(lreq[g]), .I_LDR_ADDR(laddr[g]), .O_LDR_ACK(lack[g]), .O_LDR_DATA(ldata[g]),
      .O_BUSY(busy[g]), .O_FLASH_ADDR(faddr[g]), .I_FLASH_DATA(fdata[g]),
      .O_FLASH_CE_L(ce[g]), .O_FLASH_OE_L(oe[g]), .O_ADDR_VALID_L(av[g]),
      .O_FLASH_WE_L(we[g]), .O_FLASH_CLK(fclk[g]));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset(input int d);
    last_c[d] = 1'b0;
    exp_cd[d] = '0;
    exp_ld[d] = '0;
    exp_fa[d] = '0;
  endtask
  task automatic do_reset(input int d);
    creq[d] = 0; lreq[d] = 0; rst_n[d] = 0;
    tick();
    rst_n[d] = 1;
    model_reset(d);
    tick();
  endtask
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 0; creq[d] = 0; lreq[d] = 0; beef[d] = 0; caddr[d] = '0; laddr[d] = '0;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (cack[d] !== 1'b0) begin failures++; $display("FAIL rst_cpu_ack d%0d got=%0h want=0", d, cack[d]); end
      checks++; if (lack[d] !== 1'b0) begin failures++; $display("FAIL rst_ldr_ack d%0d got=%0h want=0", d, lack[d]); end
      checks++; if (cdata[d] !== 16'h0) begin failures++; $display("FAIL rst_cpu_data d%0d got=%0h want=0", d, cdata[d]); end
      checks++; if (ldata[d] !== 16'h0) begin failures++; $display("FAIL rst_ldr_data d%0d got=%0h want=0", d, ldata[d]); end
      checks++; if (busy[d] !== 1'b0) begin failures++; $display("FAIL rst_busy d%0d got=%0h want=0", d, busy[d]); end
      checks++; if (faddr[d] !== 24'h0) begin failures++; $display("FAIL rst_faddr d%0d got=%0h want=0", d, faddr[d]); end
      checks++; if (ce[d] !== 1'b1) begin failures++; $display("FAIL rst_ce d%0d got=%0h want=1", d, ce[d]); end
      checks++; if (oe[d] !== 1'b1) begin failures++; $display("FAIL rst_oe d%0d got=%0h want=1", d, oe[d]); end
      checks++; if (av[d] !== 1'b1) begin failures++; $display("FAIL rst_av d%0d got=%0h want=1", d, av[d]); end
      checks++; if (we[d] !== 1'b1) begin failures++; $display("FAIL rst_we d%0d got=%0h want=1", d, we[d]); end
      checks++; if (fclk[d] !== 1'b1) begin failures++; $display("FAIL rst_fclk d%0d got=%0h want=1", d, fclk[d]); end
      rst_n[d] = 1;
      model_reset(d);
    end
    tick();
  endtask
  task automatic test_single();
    int n_ce = 0, first_ce = 0, n_ack = 0, ack_k = 0, n_lack = 0, n_skew = 0;
    beef[0] = 1; caddr[0] = 24'h000100; creq[0] = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ce[0] !== oe[0] || ce[0] !== av[0]) n_skew++;
      if (ce[0] === 1'b0) begin n_ce++; if (first_ce == 0) first_ce = k; end
      if (lack[0] === 1'b1) n_lack++;
      if (cack[0] === 1'b1) begin n_ack++; ack_k = k; creq[0] = 0; end
    end
    checks++; if (n_ce != 4) begin failures++; $display("FAIL single_ce_cycles got=%0d want=4", n_ce); end
    checks++; if (first_ce != 1) begin failures++; $display("FAIL single_ce_start got=%0d want=1", first_ce); end
    checks++; if (n_skew != 0) begin failures++; $display("FAIL single_strobe_skew got=%0d want=0", n_skew); end
    checks++; if (ack_k != 5) begin failures++; $display("FAIL single_ack_latency got=%0d want=5", ack_k); end
    checks++; if (n_ack != 1) begin failures++; $display("FAIL single_ack_count got=%0d want=1", n_ack); end
    checks++; if (n_lack != 0) begin failures++; $display("FAIL single_ldr_ack got=%0d want=0", n_lack); end
    checks++; if (cdata[0] !== 16'hBEEF) begin failures++; $display("FAIL single_cpu_data got=%0h want=beef", cdata[0]); end
    checks++; if (ldata[0] !== exp_ld[0]) begin failures++; $display("FAIL single_ldr_data got=%0h want=%0h", ldata[0], exp_ld[0]); end
    checks++; if (faddr[0] !== 24'h000100) begin failures++; $display("FAIL single_faddr got=%0h want=100", faddr[0]); end
    beef[0] = 0; exp_cd[0] = 16'hBEEF; last_c[0] = 1; exp_fa[0] = 24'h000100;
  endtask
  task automatic test_cpu_priority();
    int n_c = 0, n_l = 0;
    logic [23:0] ca;
    ca = 24'($urandom); caddr[0] = ca; laddr[0] = 24'($urandom); creq[0] = 1; lreq[0] = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (lack[0] === 1'b1) n_l++;
      if (cack[0] === 1'b1) begin
        n_c++;
        checks++; if (cdata[0] !== fmem(ca)) begin failures++; $display("FAIL prio_cpu_data got=%0h want=%0h", cdata[0], fmem(ca)); end
        checks++; if (faddr[0] !== ca) begin failures++; $display("FAIL prio_faddr got=%0h want=%0h", faddr[0], ca); end
        exp_cd[0] = fmem(ca); exp_fa[0] = ca;
        ca = 24'($urandom); caddr[0] = ca;
      end
    end
    creq[0] = 0; lreq[0] = 0;
    checks++; if (n_c != 3) begin failures++; $display("FAIL prio_cpu_acks got=%0d want=3", n_c); end
    checks++; if (n_l != 0) begin failures++; $display("FAIL prio_ldr_acks got=%0d want=0", n_l); end
    checks++; if (ldata[0] !== exp_ld[0]) begin failures++; $display("FAIL prio_ldr_data got=%0h want=%0h", ldata[0], exp_ld[0]); end
    last_c[0] = 1;
    tick(); tick();
  endtask
  task automatic test_drop_mid();
    int n = 0, ack_k = 0;
    logic [23:0] a;
    a = 24'($urandom); caddr[0] = a; creq[0] = 1;
    tick();
    creq[0] = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (cack[0] === 1'b1) begin n++; ack_k = k; end
    end
    checks++; if (n != 1) begin failures++; $display("FAIL drop_ack_count got=%0d want=1", n); end
    checks++; if (ack_k != 5) begin failures++; $display("FAIL drop_ack_latency got=%0d want=5", ack_k); end
    checks++; if (cdata[0] !== fmem(a)) begin failures++; $display("FAIL drop_cpu_data got=%0h want=%0h", cdata[0], fmem(a)); end
    exp_cd[0] = fmem(a); exp_fa[0] = a; last_c[0] = 1;
  endtask
  task automatic test_reset_mid();
    int n = 0, ack_k = 0, n_rst_ack = 0;
    caddr[0] = 24'h123456; creq[0] = 1;
    tick(); tick();
    #2;
    rst_n[0] = 0; creq[0] = 0;
    #1;
    checks++; if (ce[0] !== 1'b1 || oe[0] !== 1'b1 || av[0] !== 1'b1) begin failures++; $display("FAIL midrst_strobes got=%0b%0b%0b want=111", ce[0], oe[0], av[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0h want=0", busy[0]); end
    checks++; if (faddr[0] !== 24'h0) begin failures++; $display("FAIL midrst_faddr got=%0h want=0", faddr[0]); end
    for (int k = 0; k < 6; k++) begin
      if (cack[0] !== 1'b0 || lack[0] !== 1'b0) n_rst_ack++;
      if (k == 3) rst_n[0] = 1;
      tick();
    end
    checks++; if (n_rst_ack != 0) begin failures++; $display("FAIL midrst_ack got=%0d want=0", n_rst_ack); end
    model_reset(0);
    caddr[0] = 24'h000ABC; creq[0] = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (cack[0] === 1'b1) begin n++; ack_k = k; creq[0] = 0; end
    end
    checks++; if (n != 1 || ack_k != 5) begin failures++; $display("FAIL midrst_recover acks=%0d at=%0d want=1 at 5", n, ack_k); end
    checks++; if (cdata[0] !== fmem(24'h000ABC)) begin failures++; $display("FAIL midrst_data got=%0h want=%0h", cdata[0], fmem(24'h000ABC)); end
    exp_cd[0] = fmem(24'h000ABC); exp_fa[0] = 24'h000ABC; last_c[0] = 1;
  endtask
  task automatic test_round_robin();
    int idx = 0;
    bit own;
    logic [23:0] ca, la;
    do_reset(1);
    ca = 24'($urandom); la = 24'($urandom); caddr[1] = ca; laddr[1] = la; creq[1] = 1; lreq[1] = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (cack[1] === 1'b1 || lack[1] === 1'b1) begin
        own = (idx % 2) == 0;
        checks++; if (cack[1] !== own || lack[1] !== !own) begin failures++; $display("FAIL rr_owner txn%0d cpu_ack=%0h ldr_ack=%0h want_cpu=%0d", idx, cack[1], lack[1], own); end
        checks++; if (faddr[1] !== (own ? ca : la)) begin failures++; $display("FAIL rr_faddr txn%0d got=%0h want=%0h", idx, faddr[1], own ? ca : la); end
        if (own) begin
          checks++; if (cdata[1] !== fmem(ca)) begin failures++; $display("FAIL rr_cpu_data got=%0h want=%0h", cdata[1], fmem(ca)); end
          exp_cd[1] = fmem(ca); exp_fa[1] = ca; ca = 24'($urandom); caddr[1] = ca;
        end else begin
          checks++; if (ldata[1] !== fmem(la)) begin failures++; $display("FAIL rr_ldr_data got=%0h want=%0h", ldata[1], fmem(la)); end
          exp_ld[1] = fmem(la); exp_fa[1] = la; la = 24'($urandom); laddr[1] = la;
        end
        idx++;
      end
    end
    creq[1] = 0; lreq[1] = 0;
    checks++; if (idx != 4) begin failures++; $display("FAIL rr_txn_count got=%0d want=4", idx); end
    last_c[1] = 0;
    tick(); tick();
  endtask
  task automatic test_back_to_back();
    int i = 0, prev_k = 0, n_c = 0;
    laddr[1] = 24'h200000; lreq[1] = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (cack[1] === 1'b1) n_c++;
      if (lack[1] === 1'b1) begin
        checks++; if (ldata[1] !== fmem(24'h200000 + 24'(i))) begin failures++; $display("FAIL b2b_data word%0d got=%0h want=%0h", i, ldata[1], fmem(24'h200000 + 24'(i))); end
        if (i > 0) begin
          checks++; if (k - prev_k != 3) begin failures++; $display("FAIL b2b_spacing word%0d got=%0d want=3", i, k - prev_k); end
        end
        prev_k = k; i++;
        if (i == 4) lreq[1] = 0; else laddr[1] = 24'h200000 + 24'(i);
      end
    end
    checks++; if (i != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", i); end
    checks++; if (n_c != 0) begin failures++; $display("FAIL b2b_cpu_ack got=%0d want=0", n_c); end
    exp_ld[1] = fmem(24'h200003); exp_fa[1] = 24'h200003; last_c[1] = 0;
  endtask
  // reference: a grant is taken at the first edge the port is free and someone is requesting;
  // the port is then occupied for W+2 edges and the ack lands W edges after the grant
  task automatic test_random(input int d, input int ncyc);
    int w, free_e, g_e, a_e;
    bit pr, cr_q, lr_q, own_c, ec, el, es, eb;
    logic [23:0] ca_q, la_q, g_addr;
    w = wv(d); pr = (d == 0); free_e = 0; g_e = -100; a_e = -100; own_c = 0;
    do_reset(d);
    for (int e = 1; e <= ncyc; e++) begin
      cr_q = creq[d]; lr_q = lreq[d]; ca_q = caddr[d]; la_q = laddr[d];
      tick();
      if (e >= free_e && (cr_q || lr_q)) begin
        own_c = pr ? cr_q : cr_q && (!lr_q || !last_c[d]);
        last_c[d] = own_c;
        g_e = e; a_e = e + w; free_e = e + w + 2;
        g_addr = own_c ? ca_q : la_q;
        exp_fa[d] = g_addr;
      end
      ec = (e == a_e) && own_c;
      el = (e == a_e) && !own_c;
      if (ec) exp_cd[d] = fmem(g_addr);
      if (el) exp_ld[d] = fmem(g_addr);
      es = !(e >= g_e && e < g_e + w);
      eb = e >= g_e && e <= g_e + w;
      checks++; if (cack[d] !== ec) begin failures++; $display("FAIL rnd_cpu_ack d%0d cyc%0d got=%0h want=%0h", d, e, cack[d], ec); end
      checks++; if (lack[d] !== el) begin failures++; $display("FAIL rnd_ldr_ack d%0d cyc%0d got=%0h want=%0h", d, e, lack[d], el); end
      checks++; if (ce[d] !== es || oe[d] !== es || av[d] !== es) begin failures++; $display("FAIL rnd_strobes d%0d cyc%0d got=%0b%0b%0b want=%0b", d, e, ce[d], oe[d], av[d], es); end
      checks++; if (busy[d] !== eb) begin failures++; $display("FAIL rnd_busy d%0d cyc%0d got=%0h want=%0h", d, e, busy[d], eb); end
      checks++; if (faddr[d] !== exp_fa[d]) begin failures++; $display("FAIL rnd_faddr d%0d cyc%0d got=%0h want=%0h", d, e, faddr[d], exp_fa[d]); end
      checks++; if (cdata[d] !== exp_cd[d]) begin failures++; $display("FAIL rnd_cpu_data d%0d cyc%0d got=%0h want=%0h", d, e, cdata[d], exp_cd[d]); end
      checks++; if (ldata[d] !== exp_ld[d]) begin failures++; $display("FAIL rnd_ldr_data d%0d cyc%0d got=%0h want=%0h", d, e, ldata[d], exp_ld[d]); end
      if (e > ncyc - w - 4) begin
        creq[d] = 0; lreq[d] = 0;
      end else begin
        if (!creq[d]) begin creq[d] = ($urandom_range(2) == 0); caddr[d] = 24'($urandom); end
        else if (ec) begin if ($urandom_range(1) == 1) creq[d] = 0; else caddr[d] = 24'($urandom); end
        else if ($urandom_range(15) == 0) creq[d] = 0;
        else if ($urandom_range(15) == 0) caddr[d] = 24'($urandom);
        if (!lreq[d]) begin lreq[d] = ($urandom_range(2) == 0); laddr[d] = 24'($urandom); end
        else if (el) begin if ($urandom_range(1) == 1) lreq[d] = 0; else laddr[d] = 24'($urandom); end
        else if ($urandom_range(15) == 0) lreq[d] = 0;
        else if ($urandom_range(15) == 0) laddr[d] = 24'($urandom);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_cpu_priority();
    test_drop_mid();
    test_reset_mid();
    test_round_robin();
    test_back_to_back();
    test_random(0, 400);
    test_random(1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
